// File: rtl/riscv_pkg.sv
// Shared opcode, trap-cause, FSM-state and decode types
// for the fetch/decode front end.
package riscv_pkg;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_FENCE  = 7'h0F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    typedef enum logic [3:0] {
        CAUSE_MISALIGNED = 4'd0,
        CAUSE_ACCESS     = 4'd1,
        CAUSE_ILLEGAL    = 4'd2
    } trap_cause_e;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        ISSUE,
        TRAP
    } fds_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] raw;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
    } dec_t;

endpackage

// File: rtl/fetch_decode_sequencer_if.sv
// Bundles the imem port, execute handshake, redirect and trap signals.
// master = sequencer side, slave = memory/execute/trap environment.
interface fetch_decode_sequencer_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_fault;

    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic [31:0] ex_instr;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;

    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic [31:0] trap_vector;
    logic        trap_valid;
    logic [3:0]  trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_tval;
    logic        trap_ack;

    modport master (
        output imem_req_valid, imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data, imem_rsp_fault,
        output ex_valid, ex_pc, ex_instr,
        output ex_opcode, ex_funct3, ex_funct7,
        input  ex_ready,
        input  redirect_valid, redirect_pc,
        input  trap_vector, trap_ack,
        output trap_valid, trap_cause, trap_pc, trap_tval
    );

    modport slave (
        input  imem_req_valid, imem_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data, imem_rsp_fault,
        input  ex_valid, ex_pc, ex_instr,
        input  ex_opcode, ex_funct3, ex_funct7,
        output ex_ready,
        output redirect_valid, redirect_pc,
        output trap_vector, trap_ack,
        input  trap_valid, trap_cause, trap_pc, trap_tval
    );

endinterface

// File: rtl/instruction_decoder.sv
// Combinational opcode/field decoder.
// instr in; dec out (valid opcode flag, raw word, opcode/funct3/funct7).
module instruction_decoder
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [6:0] op;

    assign op = instr[6:0];

    always_comb begin
        dec        = '0;
        dec.raw    = instr;
        dec.opcode = op;
        dec.funct3 = instr[14:12];
        dec.funct7 = instr[31:25];
        unique case (1'b1)
            (op == OP_LUI),
            (op == OP_AUIPC),
            (op == OP_JAL),
            (op == OP_JALR),
            (op == OP_BRANCH),
            (op == OP_LOAD),
            (op == OP_STORE),
            (op == OP_IMM),
            (op == OP_REG),
            (op == OP_FENCE),
            (op == OP_SYSTEM): dec.valid = 1'b1;
            default:           dec.valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_decode_sequencer.sv
// Fetch/decode sequencer: owns the fetch PC, issues word fetches,
// decodes responses and hands instructions to execute or raises traps.
// Ports: clk, rst_n (async, active low), enable, bus (master modport).
module fetch_decode_sequencer
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    fetch_decode_sequencer_if.master  bus
);

    fds_state_e  state_q;
    logic [31:0] pc_q;
    logic        kill_q;

    logic        ex_valid_q;
    logic [31:0] ex_pc_q;
    logic [31:0] ex_instr_q;
    logic [6:0]  ex_opcode_q;
    logic [2:0]  ex_funct3_q;
    logic [6:0]  ex_funct7_q;

    logic        trap_valid_q;
    trap_cause_e trap_cause_q;
    logic [31:0] trap_pc_q;
    logic [31:0] trap_tval_q;

    dec_t        dec;
    logic        req_valid;
    logic        req_fire;
    logic        redir_take;
    logic        redir_mis;
    logic        kill_set;

    instruction_decoder u_dec (
        .instr (bus.imem_rsp_data),
        .dec   (dec)
    );

    assign req_valid  = (state_q == REQ) && !kill_q;
    assign req_fire   = req_valid && bus.imem_req_ready;
    assign redir_take = bus.redirect_valid && (state_q != TRAP);
    assign redir_mis  = |bus.redirect_pc[1:0];

    // A redirect orphans an accepted request or an unanswered one;
    // a response arriving with the redirect is simply dropped.
    assign kill_set = (state_q == REQ && req_fire)
                   || (state_q == WAIT && !bus.imem_rsp_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            kill_q       <= 1'b0;
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= '0;
            ex_instr_q   <= '0;
            ex_opcode_q  <= '0;
            ex_funct3_q  <= '0;
            ex_funct7_q  <= '0;
            trap_valid_q <= 1'b0;
            trap_cause_q <= CAUSE_MISALIGNED;
            trap_pc_q    <= '0;
            trap_tval_q  <= '0;
        end else begin
            if (kill_q && bus.imem_rsp_valid)
                kill_q <= 1'b0;
            if (redir_take) begin
                ex_valid_q <= 1'b0;
                if (kill_set)
                    kill_q <= 1'b1;
                if (redir_mis) begin
                    state_q      <= TRAP;
                    trap_valid_q <= 1'b1;
                    trap_cause_q <= CAUSE_MISALIGNED;
                    trap_pc_q    <= bus.redirect_pc;
                    trap_tval_q  <= bus.redirect_pc;
                end else begin
                    pc_q    <= bus.redirect_pc;
                    state_q <= REQ;
                end
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (enable)
                            state_q <= REQ;
                    end
                    REQ: begin
                        if (req_fire)
                            state_q <= WAIT;
                    end
                    WAIT: begin
                        if (bus.imem_rsp_valid && !kill_q) begin
                            priority case (1'b1)
                                bus.imem_rsp_fault: begin
                                    state_q      <= TRAP;
                                    trap_valid_q <= 1'b1;
                                    trap_cause_q <= CAUSE_ACCESS;
                                    trap_pc_q    <= pc_q;
                                    trap_tval_q  <= pc_q;
                                end
                                !dec.valid: begin
                                    state_q      <= TRAP;
                                    trap_valid_q <= 1'b1;
                                    trap_cause_q <= CAUSE_ILLEGAL;
                                    trap_pc_q    <= pc_q;
                                    trap_tval_q  <= dec.raw;
                                end
                                default: begin
                                    state_q     <= ISSUE;
                                    ex_valid_q  <= 1'b1;
                                    ex_pc_q     <= pc_q;
                                    ex_instr_q  <= dec.raw;
                                    ex_opcode_q <= dec.opcode;
                                    ex_funct3_q <= dec.funct3;
                                    ex_funct7_q <= dec.funct7;
                                end
                            endcase
                        end
                    end
                    ISSUE: begin
                        if (bus.ex_ready) begin
                            ex_valid_q <= 1'b0;
                            pc_q       <= pc_q + 32'd4;
                            state_q    <= enable ? REQ : IDLE;
                        end
                    end
                    TRAP: begin
                        if (bus.trap_ack) begin
                            trap_valid_q <= 1'b0;
                            pc_q         <= bus.trap_vector;
                            state_q      <= REQ;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_addr      = pc_q;
    assign bus.ex_valid       = ex_valid_q;
    assign bus.ex_pc          = ex_pc_q;
    assign bus.ex_instr       = ex_instr_q;
    assign bus.ex_opcode      = ex_opcode_q;
    assign bus.ex_funct3      = ex_funct3_q;
    assign bus.ex_funct7      = ex_funct7_q;
    assign bus.trap_valid     = trap_valid_q;
    assign bus.trap_cause     = trap_cause_q;
    assign bus.trap_pc        = trap_pc_q;
    assign bus.trap_tval      = trap_tval_q;

endmodule

// File: tb/tb_fetch_decode_sequencer.sv
// Scoreboard bench for fetch_decode_sequencer: directed phases push
// expected issues/traps; a monitor pops them at each handshake.
module tb_fetch_decode_sequencer;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
    } ex_exp_t;

    typedef struct {
        logic [3:0]  cause;
        logic [31:0] pc;
        logic [31:0] tval;
    } tr_exp_t;

    logic clk;
    logic rst_n;
    logic enable;

    fetch_decode_sequencer_if bus ();

    fetch_decode_sequencer #(.RESET_PC(32'h0)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat = 1;
    int acc_count = 0;

    ex_exp_t exq[$];
    tr_exp_t trq[$];

    logic [31:0] mem [logic [31:0]];
    bit          fault_mem [logic [31:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic push_ex(input logic [31:0] pc,
                           input logic [31:0] instr,
                           input logic [6:0] op,
                           input logic [2:0] f3,
                           input logic [6:0] f7);
        ex_exp_t e;
        e.pc = pc; e.instr = instr;
        e.op = op; e.f3 = f3; e.f7 = f7;
        exq.push_back(e);
    endtask

    task automatic push_tr(input logic [3:0] cause,
                           input logic [31:0] pc,
                           input logic [31:0] tval);
        tr_exp_t t;
        t.cause = cause; t.pc = pc; t.tval = tval;
        trq.push_back(t);
    endtask

    task automatic wait_ex(input string nm);
        int n = 0;
        while (bus.ex_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.ex_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s ex_valid timeout got=0 exp=1", nm);
        end
    endtask

    task automatic wait_trap(input string nm);
        int n = 0;
        while (bus.trap_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.trap_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s trap_valid timeout got=0 exp=1", nm);
        end
    endtask

    task automatic ack_trap(input logic [31:0] vec);
        @(negedge clk);
        bus.trap_vector = vec;
        bus.trap_ack = 1'b1;
        @(negedge clk);
        bus.trap_ack = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = pc;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem.exists(a))
            return mem[a];
        return 32'h0000_0013;
    endfunction

    // Memory model: one response per accepted request, lat cycles later.
    initial begin
        int cnt = 0;
        bit acc_next = 0;
        logic [31:0] acc_addr = '0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = '0;
        bus.imem_rsp_fault = 1'b0;
        forever begin
            @(negedge clk);
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_fault = 1'b0;
            if (acc_next) begin
                cnt = lat;
                acc_next = 0;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data = mem_word(acc_addr);
                    bus.imem_rsp_fault = fault_mem.exists(acc_addr);
                end
            end
            #1;
            if (rst_n && bus.imem_req_valid && bus.imem_req_ready) begin
                checks++;
                if (cnt != 0 || bus.imem_rsp_valid) begin
                    errors++;
                    $display("FAIL outstanding req addr=%h while busy exp=idle",
                             bus.imem_addr);
                end
                acc_next = 1;
                acc_addr = bus.imem_addr;
                acc_count++;
            end
        end
    end

    // Monitor: compares each ex handshake and trap ack to the queues.
    initial begin
        ex_exp_t e;
        tr_exp_t t;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && bus.ex_valid && bus.ex_ready
                && !bus.redirect_valid) begin
                checks++;
                if (exq.size() == 0) begin
                    errors++;
                    $display("FAIL ex_unexpected got pc=%h instr=%h exp=none",
                             bus.ex_pc, bus.ex_instr);
                end else begin
                    e = exq.pop_front();
                    if (bus.ex_pc !== e.pc || bus.ex_instr !== e.instr
                        || bus.ex_opcode !== e.op
                        || bus.ex_funct3 !== e.f3
                        || bus.ex_funct7 !== e.f7) begin
                        errors++;
                        $display("FAIL ex_issue got pc=%h i=%h op=%h f3=%h f7=%h exp pc=%h i=%h op=%h f3=%h f7=%h",
                                 bus.ex_pc, bus.ex_instr, bus.ex_opcode,
                                 bus.ex_funct3, bus.ex_funct7,
                                 e.pc, e.instr, e.op, e.f3, e.f7);
                    end
                end
            end
            if (rst_n && bus.trap_valid && bus.trap_ack) begin
                checks++;
                if (trq.size() == 0) begin
                    errors++;
                    $display("FAIL trap_unexpected got cause=%0d pc=%h exp=none",
                             bus.trap_cause, bus.trap_pc);
                end else begin
                    t = trq.pop_front();
                    if (bus.trap_cause !== t.cause || bus.trap_pc !== t.pc
                        || bus.trap_tval !== t.tval) begin
                        errors++;
                        $display("FAIL trap got cause=%0d pc=%h tval=%h exp cause=%0d pc=%h tval=%h",
                                 bus.trap_cause, bus.trap_pc, bus.trap_tval,
                                 t.cause, t.pc, t.tval);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1;
        int t2;
        int c0;
        int n;
        enable = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.ex_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.trap_vector = '0;
        bus.trap_ack = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        chk("rst_ex_valid", {31'b0, bus.ex_valid}, 32'd0);
        chk("rst_trap_valid", {31'b0, bus.trap_valid}, 32'd0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_ex_pc", bus.ex_pc, 32'h0);
        chk("rst_ex_instr", bus.ex_instr, 32'h0);
        chk("rst_trap_tval", bus.trap_tval, 32'h0);

        rst_n = 1'b1;
        // basic flow and 3-cycle cadence
        lat = 1;
        bus.ex_ready = 1'b1;
        push_ex(32'h0, 32'h13, 7'h13, 3'h0, 7'h0);
        push_ex(32'h4, 32'h13, 7'h13, 3'h0, 7'h0);
        enable = 1'b1;
        wait_ex("first");
        t1 = cyc;
        @(negedge clk);
        wait_ex("second");
        t2 = cyc;
        chk("cadence", t2 - t1, 32'd3);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        chk("halt_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        chk("halt_addr", bus.imem_addr, 32'h8);

        // illegal opcode, then trap vector
        mem[32'h8] = 32'hFFFF_FFFF;
        push_tr(4'd2, 32'h8, 32'hFFFF_FFFF);
        push_ex(32'h100, 32'h13, 7'h13, 3'h0, 7'h0);
        enable = 1'b1;
        wait_trap("illegal");
        ack_trap(32'h100);
        chk("vector_addr", bus.imem_addr, 32'h100);
        wait_ex("after_vector");
        enable = 1'b0;
        repeat (3) @(negedge clk);

        // access fault beats illegal opcode
        fault_mem[32'h8] = 1'b1;
        push_tr(4'd1, 32'h8, 32'h8);
        push_ex(32'h200, 32'h13, 7'h13, 3'h0, 7'h0);
        redirect(32'h8);
        wait_trap("fault");
        ack_trap(32'h200);
        wait_ex("after_fault");
        repeat (3) @(negedge clk);
        chk("fault_halt_addr", bus.imem_addr, 32'h204);

        // redirect in WAIT discards the stale response
        lat = 3;
        mem[32'h40] = 32'h40B5_0533;
        push_ex(32'h40, 32'h40B5_0533, 7'h33, 3'h0, 7'h20);
        c0 = acc_count;
        enable = 1'b1;
        n = 0;
        while (acc_count == c0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wait_accept_seen", {31'b0, acc_count != c0}, 32'd1);
        redirect(32'h40);
        wait_ex("redir_wait");
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("redir_halt_addr", bus.imem_addr, 32'h44);

        // misaligned redirect in ISSUE beats the handshake
        lat = 1;
        push_tr(4'd0, 32'h42, 32'h42);
        push_ex(32'h300, 32'h13, 7'h13, 3'h0, 7'h0);
        enable = 1'b1;
        wait_ex("issue_44");
        enable = 1'b0;
        redirect(32'h42);
        chk("redir_ex_drop", {31'b0, bus.ex_valid}, 32'd0);
        chk("redir_trap", {31'b0, bus.trap_valid}, 32'd1);
        ack_trap(32'h300);
        wait_ex("after_mis");
        repeat (3) @(negedge clk);

        // backpressure holds ex_*, then halt
        mem[32'h304] = 32'h0011_2023;
        push_ex(32'h304, 32'h0011_2023, 7'h23, 3'h2, 7'h0);
        bus.ex_ready = 1'b0;
        enable = 1'b1;
        wait_ex("bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_pc", bus.ex_pc, 32'h304);
            chk("hold_instr", bus.ex_instr, 32'h0011_2023);
        end
        enable = 1'b0;
        bus.ex_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_idle_req", {31'b0, bus.imem_req_valid}, 32'd0);
        end
        chk("bp_addr", bus.imem_addr, 32'h308);
        chk("bp_ex_valid", {31'b0, bus.ex_valid}, 32'd0);

        // PC wraps modulo 2^32
        push_ex(32'hFFFF_FFFC, 32'h13, 7'h13, 3'h0, 7'h0);
        redirect(32'hFFFF_FFFC);
        wait_ex("wrap");
        repeat (2) @(negedge clk);
        chk("wrap_addr", bus.imem_addr, 32'h0);
        chk("wrap_req", {31'b0, bus.imem_req_valid}, 32'd0);

        repeat (3) @(negedge clk);
        chk("exq_empty", exq.size(), 32'd0);
        chk("trq_empty", trq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
